// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with architectural HI/LO.
// The result is computed combinationally at acceptance and held in pending
// registers. It is committed to HI/LO after a fixed latency unless a flush
// or a reset discards it first.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES - 1);
  localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q;
  logic [4:0]  count_q;
  logic [31:0] pend_hi_q, pend_lo_q;
  logic [31:0] hi_q, lo_q;
  logic        busy_q;

  logic [63:0] prod_s, prod_u;
  logic [31:0] dvd_mag, dvs_mag, dvs_safe;
  logic [31:0] quo_mag, rem_mag;
  logic        sgn_div, neg_quo, neg_rem;
  logic [31:0] res_hi_d, res_lo_d;

  // Both products are formed in 64 bits; sign-extending the operands makes
  // the low 64 bits of the unsigned multiply equal the signed product.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'h0, a} * {32'h0, b};

  // Divide on magnitudes and restore signs afterwards. This yields truncation
  // toward zero and a remainder carrying the dividend's sign, and it also
  // gives 0x80000000 / -1 = 0x80000000 rem 0 without special handling.
  always_comb begin
    sgn_div  = (op == OP_DIV);
    dvd_mag  = (sgn_div && a[31]) ? (~a + 32'd1) : a;
    dvs_mag  = (sgn_div && b[31]) ? (~b + 32'd1) : b;
    dvs_safe = (dvs_mag == '0) ? 32'd1 : dvs_mag;
    quo_mag  = dvd_mag / dvs_safe;
    rem_mag  = dvd_mag % dvs_safe;
    neg_quo  = sgn_div && (a[31] ^ b[31]);
    neg_rem  = sgn_div && a[31];
  end

  // Select the pending result for the operation being accepted.
  always_comb begin
    res_hi_d = '0;
    res_lo_d = '0;
    case (op)
      OP_MULT: begin
        res_hi_d = prod_s[63:32];
        res_lo_d = prod_s[31:0];
      end
      OP_MULTU: begin
        res_hi_d = prod_u[63:32];
        res_lo_d = prod_u[31:0];
      end
      OP_DIV, OP_DIVU: begin
        if (b == '0) begin
          res_hi_d = a;
          res_lo_d = '1;
        end else begin
          res_hi_d = neg_rem ? (~rem_mag + 32'd1) : rem_mag;
          res_lo_d = neg_quo ? (~quo_mag + 32'd1) : quo_mag;
        end
      end
      default: begin
        res_hi_d = '0;
        res_lo_d = '0;
      end
    endcase
  end

  // Control FSM: accept ops in IDLE, count down in RUN, commit or abort.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !flush) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                pend_hi_q <= res_hi_d;
                pend_lo_q <= res_lo_d;
                count_q   <= MULT_LOAD;
                busy_q    <= 1'b1;
                state_q   <= RUN;
              end
              OP_DIV, OP_DIVU: begin
                pend_hi_q <= res_hi_d;
                pend_lo_q <= res_lo_d;
                count_q   <= DIV_LOAD;
                busy_q    <= 1'b1;
                state_q   <= RUN;
              end
              OP_MTHI: hi_q <= a;
              OP_MTLO: lo_q <= a;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (flush) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (count_q == '0) begin
            hi_q    <= pend_hi_q;
            lo_q    <= pend_lo_q;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            count_q <= count_q - 5'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Testbench for md_unit: table vectors, hand-written corner sequences and
// random operations checked against an arithmetic reference model.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        flush;
  logic        busy;
  logic [31:0] hi, lo;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] m_hi, m_lo;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, exp_hi, exp_lo;
    string       name;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Architectural meaning of each op, computed with wide integer arithmetic.
  function automatic void ref_md(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                 input logic [31:0] ch, input logic [31:0] cl,
                                 output logic [31:0] rh, output logic [31:0] rl);
    longint      sx, sy, q, r;
    logic [63:0] p, qq, rr;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    rh = ch;
    rl = cl;
    case (o)
      3'd0: begin p = 64'(sx * sy); rh = p[63:32]; rl = p[31:0]; end
      3'd1: begin p = {32'h0, x} * {32'h0, y}; rh = p[63:32]; rl = p[31:0]; end
      3'd2: begin
        if (y == 0) begin rh = x; rl = 32'hFFFFFFFF; end
        else begin
          q = sx / sy; r = sx % sy;
          qq = 64'(q); rr = 64'(r);
          rl = qq[31:0]; rh = rr[31:0];
        end
      end
      3'd3: begin
        if (y == 0) begin rh = x; rl = 32'hFFFFFFFF; end
        else begin rl = x / y; rh = x % y; end
      end
      3'd4: rh = x;
      3'd5: rl = x;
      default: ;
    endcase
  endfunction

  function automatic int unsigned lat(input logic [2:0] o);
    if (o <= 3'd1) return 5;
    if (o <= 3'd3) return 10;
    return 0;
  endfunction

  // Called at a negedge; start is sampled at the following posedge.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 3'd6;
  endtask

  task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
    int unsigned n;
    n = lat(o);
    issue(o, x, y);
    for (int unsigned k = 0; k < n; k++) begin
      chk({nm, " busy"}, 32'(busy), 32'd1);
      chk({nm, " hi hold"}, hi, m_hi);
      chk({nm, " lo hold"}, lo, m_lo);
      @(negedge clk);
    end
    chk({nm, " busy end"}, 32'(busy), 32'd0);
    chk({nm, " hi"}, hi, eh);
    chk({nm, " lo"}, lo, el);
    m_hi = eh;
    m_lo = el;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] eh, el;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    tbl[0]  = '{3'd4, 32'h12345678, 32'h0,        32'h12345678, 32'h00000000, "mthi"};
    tbl[1]  = '{3'd5, 32'hCAFEF00D, 32'h0,        32'h12345678, 32'hCAFEF00D, "mtlo"};
    tbl[2]  = '{3'd6, 32'h00000001, 32'h2,        32'h12345678, 32'hCAFEF00D, "nop6"};
    tbl[3]  = '{3'd7, 32'h00000003, 32'h4,        32'h12345678, 32'hCAFEF00D, "nop7"};
    tbl[4]  = '{3'd1, 32'hFFFFFFFF, 32'h2,        32'h00000001, 32'hFFFFFFFE, "multu"};
    tbl[5]  = '{3'd0, 32'hFFFFFFFD, 32'h4,        32'hFFFFFFFF, 32'hFFFFFFF4, "mult neg"};
    tbl[6]  = '{3'd2, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, "div -7/2"};
    tbl[7]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div ovf"};
    tbl[8]  = '{3'd3, 32'h00000007, 32'h0,        32'h00000007, 32'hFFFFFFFF, "divu /0"};
    tbl[9]  = '{3'd2, 32'h00000005, 32'h0,        32'h00000005, 32'hFFFFFFFF, "div /0"};
    tbl[10] = '{3'd2, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 32'hFFFFFFFF, "div neg/0"};
    tbl[11] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult min^2"};
    tbl[12] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "multu 2^62"};
    tbl[13] = '{3'd0, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, "mult max*-1"};
    tbl[14] = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div 7/-2"};
    tbl[15] = '{3'd3, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, "divu big"};
    tbl[16] = '{3'd5, 32'h0BADBEEF, 32'h0,        32'h0000000F, 32'h0BADBEEF, "mtlo b2b"};

    reset_n = 1'b0; start = 1'b0; op = 3'd6; a = '0; b = '0; flush = 1'b0;
    #2;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset hi", hi, 32'h0);
    chk("reset lo", lo, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    m_hi = '0; m_lo = '0;

    // Reset mid-operation clears state asynchronously and drops the result.
    run_op("pre-reset mthi", 3'd4, 32'hAAAA5555, 32'h0, 32'hAAAA5555, 32'h0);
    issue(3'd1, 32'hFFFFFFFF, 32'h2);
    @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rst mid busy", 32'(busy), 32'd0);
    chk("rst mid hi", hi, 32'h0);
    chk("rst mid lo", lo, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("rst late busy", 32'(busy), 32'd0);
    chk("rst late hi", hi, 32'h0);
    chk("rst late lo", lo, 32'h0);
    m_hi = '0; m_lo = '0;

    foreach (tbl[i])
      run_op(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp_hi, tbl[i].exp_lo);

    // mtlo and div issued while busy are ignored; the mult still commits.
    issue(3'd0, 32'h3, 32'h5);
    start = 1'b1; op = 3'd5; a = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b1; op = 3'd2; a = 32'h64; b = 32'h7;
    @(negedge clk);
    start = 1'b0; op = 3'd6;
    for (int unsigned k = 2; k < 5; k++) begin
      chk("busy-mtlo busy", 32'(busy), 32'd1);
      chk("busy-mtlo lo hold", lo, m_lo);
      @(negedge clk);
    end
    chk("busy-mtlo busy end", 32'(busy), 32'd0);
    chk("busy-mtlo hi", hi, 32'h0);
    chk("busy-mtlo lo", lo, 32'hF);
    m_hi = 32'h0; m_lo = 32'hF;
    repeat (12) @(negedge clk);
    chk("busy-div no commit hi", hi, m_hi);
    chk("busy-div no commit lo", lo, m_lo);

    // Flush sampled on cycle 9 of a div, then on the commit edge itself.
    for (int unsigned w = 8; w <= 9; w++) begin
      issue(3'd2, 32'h64, 32'h7);
      repeat (w) @(negedge clk);
      chk("flush pre busy", 32'(busy), 32'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush busy", 32'(busy), 32'd0);
      chk("flush hi", hi, m_hi);
      chk("flush lo", lo, m_lo);
      repeat (4) @(negedge clk);
      chk("flush late hi", hi, m_hi);
      chk("flush late lo", lo, m_lo);
    end

    // Flush alongside a start in IDLE suppresses the start.
    flush = 1'b1;
    issue(3'd0, 32'h3, 32'h5);
    chk("flush-idle mult busy", 32'(busy), 32'd0);
    issue(3'd4, 32'h55AA55AA, 32'h0);
    flush = 1'b0;
    chk("flush-idle mthi hi", hi, m_hi);
    repeat (6) @(negedge clk);
    chk("flush-idle late lo", lo, m_lo);

    // Random operations against the reference model.
    for (int unsigned n = 0; n < 30; n++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      ref_md(ro, ra, rb, m_hi, m_lo, eh, el);
      run_op($sformatf("rnd%0d op%0d", n, ro), ro, ra, rb, eh, el);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit for the EX stage of the 5-stage MIPS core.
- Executes mult/multu/div/divu over multiple cycles and services mthi/mtlo.
- Holds the architectural HI/LO registers, which the write-back path selects when WDataSrc is WDATA_HI or WDATA_LO (mfhi/mflo).
- Drives `busy` so the hazard unit stalls any mult/div/mthi/mtlo/mfhi/mflo that reaches EX while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, cycles from accepted mult/multu to HI/LO commit (range 1..31).
- DIV_CYCLES, 10, cycles from accepted div/divu to HI/LO commit (range 1..31).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  operation valid in EX this cycle.
- op  input  3  0=mult, 1=multu, 2=div, 3=divu, 4=mthi, 5=mtlo; 6 and 7 are no-ops.
- a  input  32  rs operand; also the mthi/mtlo source.
- b  input  32  rt operand.
- flush  input  1  exception/eret flush; aborts any in-flight operation.
- busy  output  1  operation in flight; HI/LO not yet final.
- hi  output  32  committed HI register.
- lo  output  32  committed LO register.

Behaviour:
- **Reset:** reset_n low asynchronously clears hi=0, lo=0, busy=0, count=0, state=IDLE and pending results. A reset mid-operation discards the operation.
- **States:** IDLE and RUN.
- **IDLE, start=1, op in 0..3:**
  - Compute the result combinationally from a and b and latch it into pending_hi/pending_lo.
  - Load count with MULT_CYCLES-1 or DIV_CYCLES-1.
  - Go to RUN with busy=1 from that edge.
- **IDLE, start=1, op=4:** hi<=a at the edge; no busy.
- **IDLE, start=1, op=5:** lo<=a at the edge; no busy.
- **IDLE, op 6/7 or start=0:** no effect.
- **RUN:**
  - count decrements each edge.
  - On the edge where count==0: hi<=pending_hi, lo<=pending_lo, busy<=0, go to IDLE.
  - Net timing: start sampled at edge E0; commit and busy fall at edge E0+N, where N is MULT_CYCLES or DIV_CYCLES. busy is high for exactly N cycles.
- **start while busy:** ignored completely, including mthi/mtlo. The hazard unit guarantees no such start is issued; the bench checks that hi/lo are unchanged if one is.
- **flush:**
  - In RUN: go to IDLE and clear busy at the next edge; pending results are discarded and hi/lo keep their prior values.
  - Flush on the same edge as the count==0 commit: the flush wins and there is no commit.
  - Flush with start in IDLE: start is ignored.
- **mult:** signed 32x32 -> 64; hi = product[63:32], lo = product[31:0].
- **multu:** as mult, unsigned.
- **div (signed):**
  - lo = quotient, truncated toward zero.
  - hi = remainder, with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- **divu:** unsigned quotient to lo, remainder to hi.
- **Divide by zero (div or divu):** lo=0xFFFFFFFF, hi=a. Full latency still applies; no exception is raised.
- **Back-to-back:** a new start is accepted in the cycle after busy falls. That start sees the newly committed hi/lo for mthi/mtlo ordering.
- **Outputs:** hi and lo are registered with no combinational path from the inputs.

Test Plan:
- **Reset mid-op:** multu a=0xFFFFFFFF b=2, pull reset_n low 2 cycles after start -> busy=0, hi=0, lo=0 immediately (asynchronous), with no later commit.
- **multu timing:** multu a=0xFFFFFFFF b=2 -> busy high 5 cycles, then hi=0x00000001, lo=0xFFFFFFFE; hi/lo unchanged before that edge.
- **mult sign:** mult a=0xFFFFFFFD(-3) b=4 -> hi=0xFFFFFFFF, lo=0xFFFFFFF4.
- **div sign and overflow:**
  - div a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 cycles.
  - div a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- **Divide by zero and flush:**
  - divu a=7 b=0 -> hi=7, lo=0xFFFFFFFF after 10 cycles.
  - Separately, div with flush asserted on cycle 9 -> busy=0, hi/lo keep their old values.
- **mthi/mtlo:**
  - mthi a=0x12345678 -> hi updates at the next edge, busy stays 0.
  - mtlo issued while a mult is busy -> lo unchanged until the mult commits.
